const_unit: RTL and testbench



---
 rtl/const_pkg.sv | 9 +
 rtl/const_unit_if.sv | 30 +++
 rtl/const_shadow_reg.sv | 21 ++
 rtl/const_unit.sv | 47 ++++
 tb/tb_const_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/const_pkg.sv
// Shared widths and word type for the Versat constant-source unit.
package const_pkg;

   localparam int unsigned CONST_DATA_W_DEFAULT = 32;
   localparam int unsigned CONST_DATA_W_MAX     = 64;

   typedef logic [CONST_DATA_W_MAX-1:0] const_word_t;

endpackage : const_pkg

// File: rtl/const_unit_if.sv
// Datapath/control bundle between the accelerator and a constant unit.
interface const_unit_if
   import const_pkg::*;
#(
   parameter int unsigned DATA_W = CONST_DATA_W_DEFAULT
) ();

   logic              run;
   logic              running;
   logic              done;
   logic [DATA_W-1:0] constant;
   logic [DATA_W-1:0] out0;

   modport master (
      output run,
      output running,
      output constant,
      input  done,
      input  out0
   );

   modport slave (
      input  run,
      input  running,
      input  constant,
      output done,
      output out0
   );

endinterface : const_unit_if

// File: rtl/const_shadow_reg.sv
// DATA_W-wide register with load enable and synchronous active-low clear.
module const_shadow_reg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   // Clear dominates a coincident load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule : const_shadow_reg

// File: rtl/const_unit.sv
// Constant-source functional unit: presents a configuration word on out0.
// CONST_SHADOW_EN builds a shadow register reloaded only on run pulses.
module const_unit
   import const_pkg::*;
#(
   parameter int unsigned DATA_W = CONST_DATA_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   const_unit_if.slave  bus
);

   if (DATA_W < 1 || DATA_W > CONST_DATA_W_MAX) begin : g_bad_width
      $fatal(1, "const_unit: DATA_W=%0d outside 1..%0d", DATA_W, CONST_DATA_W_MAX);
   end

   // The unit never stalls the run, so it always reports finished.
   assign bus.done = 1'b1;

`ifdef CONST_SHADOW_EN

   logic [DATA_W-1:0] act_q;
   logic              unused_running;

   const_shadow_reg #(
      .DATA_W (DATA_W)
   ) u_shadow (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (bus.run),
      .d     (bus.constant),
      .q     (act_q)
   );

   assign bus.out0       = act_q;
   assign unused_running = bus.running;

`else

   logic unused_ctrl;

   assign bus.out0    = bus.constant;
   assign unused_ctrl = ^{clk, rst_n, bus.run, bus.running};

`endif

endmodule : const_unit

// File: tb/tb_const_unit.sv
// Directed self-checking bench for const_unit (passthrough or shadow build).
module tb_const_unit;
   import const_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   const_unit_if #(.DATA_W(1))  b1_if ();
   const_unit_if #(.DATA_W(32)) b32_if ();

   const_unit #(.DATA_W(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1_if.slave)
   );

   const_unit #(.DATA_W(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b32_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input const_word_t obs, input const_word_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst_n            = 1'b0;
      b1_if.run        = 1'b0;
      b1_if.running    = 1'b0;
      b1_if.constant   = 1'b0;
      b32_if.run       = 1'b0;
      b32_if.running   = 1'b0;
      b32_if.constant  = 32'h0;

`ifdef CONST_SHADOW_EN
      // Reset with a nonzero word pending
      b32_if.constant = 32'hA5A5A5A5;
      b1_if.constant  = 1'b1;
      tick();
      tick();
      check("rst_out0",      const_word_t'(b32_if.out0), 64'h0);
      check("rst_done",      const_word_t'(b32_if.done), 64'h1);
      check("rst_out0_w1",   const_word_t'(b1_if.out0),  64'h0);

      // Load, then config changes without run must not propagate
      rst_n           = 1'b1;
      b32_if.constant = 32'h12345678;
      check("pre_load",      const_word_t'(b32_if.out0), 64'h0);
      b32_if.run      = 1'b1;
      b1_if.run       = 1'b1;
      tick();
      b32_if.run      = 1'b0;
      b1_if.run       = 1'b0;
      check("load",          const_word_t'(b32_if.out0), 64'h12345678);
      check("load_w1",       const_word_t'(b1_if.out0),  64'h1);
      b32_if.constant = 32'h0BADF00D;
      b1_if.constant  = 1'b0;
      #2;
      check("hold_comb",     const_word_t'(b32_if.out0), 64'h12345678);
      tick();
      tick();
      check("hold",          const_word_t'(b32_if.out0), 64'h12345678);
      check("hold_w1",       const_word_t'(b1_if.out0),  64'h1);

      // running alone leaves the register untouched
      b32_if.running  = 1'b1;
      tick();
      check("running_hold",  const_word_t'(b32_if.out0), 64'h12345678);

      // Reset asserted mid-run clears and stays clear
      rst_n           = 1'b0;
      tick();
      check("midrun_rst",    const_word_t'(b32_if.out0), 64'h0);
      check("midrun_done",   const_word_t'(b32_if.done), 64'h1);
      rst_n           = 1'b1;
      tick();
      check("post_rst_hold", const_word_t'(b32_if.out0), 64'h0);
      b32_if.running  = 1'b0;

      // Reset wins over a coincident run
      rst_n           = 1'b0;
      b32_if.constant = 32'hFFFFFFFF;
      b32_if.run      = 1'b1;
      tick();
      check("conflict",      const_word_t'(b32_if.out0), 64'h0);
      rst_n           = 1'b1;
      tick();
      b32_if.run      = 1'b0;
      check("run_after",     const_word_t'(b32_if.out0), 64'hFFFFFFFF);

      // Back-to-back run pulses
      b32_if.constant = 32'h1;
      b32_if.run      = 1'b1;
      tick();
      check("b2b_first",     const_word_t'(b32_if.out0), 64'h1);
      b32_if.constant = 32'h2;
      tick();
      b32_if.run      = 1'b0;
      check("b2b_second",    const_word_t'(b32_if.out0), 64'h2);
      b32_if.constant = 32'h3;
      tick();
      check("b2b_hold",      const_word_t'(b32_if.out0), 64'h2);
`else
      // Width 1 passthrough, stepped without relying on the clock
      b1_if.constant = 1'b0;
      #10;
      check("w1_0a",         const_word_t'(b1_if.out0), 64'h0);
      b1_if.constant = 1'b1;
      #10;
      check("w1_1",          const_word_t'(b1_if.out0), 64'h1);
      b1_if.constant = 1'b0;
      #10;
      check("w1_0b",         const_word_t'(b1_if.out0), 64'h0);

      // Width 32 passthrough, immediate follow
      b32_if.constant = 32'hDEADBEEF;
      #1;
      check("w32_deadbeef",  const_word_t'(b32_if.out0), 64'hDEADBEEF);
      check("w32_done_a",    const_word_t'(b32_if.done), 64'h1);
      b32_if.constant = 32'h00000000;
      #1;
      check("w32_zero",      const_word_t'(b32_if.out0), 64'h0);
      b32_if.constant = 32'hFFFFFFFF;
      #1;
      check("w32_ones",      const_word_t'(b32_if.out0), 64'hFFFFFFFF);
      check("w32_done_b",    const_word_t'(b32_if.done), 64'h1);

      // Reset, run and running must not disturb the passthrough
      b32_if.constant = 32'hA5A5A5A5;
      tick();
      check("rst_passthru",  const_word_t'(b32_if.out0), 64'hA5A5A5A5);
      check("rst_done",      const_word_t'(b32_if.done), 64'h1);
      rst_n           = 1'b1;
      b32_if.run      = 1'b1;
      b32_if.running  = 1'b1;
      b32_if.constant = 32'h12345678;
      tick();
      b32_if.run      = 1'b0;
      check("run_passthru",  const_word_t'(b32_if.out0), 64'h12345678);
      b32_if.constant = 32'h0BADF00D;
      #1;
      check("no_run_follow", const_word_t'(b32_if.out0), 64'h0BADF00D);
      b1_if.constant  = 1'b1;
      b1_if.run       = 1'b1;
      tick();
      check("w1_ctrl",       const_word_t'(b1_if.out0), 64'h1);
      check("w1_done",       const_word_t'(b1_if.done), 64'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_const_unit
